// File: rtl/multi_bit_sync_filter_pkg.sv
// Shared definitions for the multi-channel synchronizer/glitch filter.
package multi_bit_sync_filter_pkg;

    localparam int unsigned DEF_NUM_STAGES    = 2;
    localparam int unsigned DEF_FILTER_CYCLES = 4;

    // Counter width needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

    // Filter counter width for the default filter length.
    localparam int unsigned CNT_W = clog2_min1(DEF_FILTER_CYCLES);

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: synchronizer chain, stability filter, rise/fall event flops.
module sync_filter_chan
    import multi_bit_sync_filter_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic        INIT_BIT      = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic ASYNC,
    input  logic FILT_BYPASS,
    output logic SYNC,
    output logic RISE,
    output logic FALL,
    output logic edge_c
);

    localparam int unsigned            CNT_WIDTH = clog2_min1(FILTER_CYCLES);
    localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(FILTER_CYCLES - 1);

    logic [NUM_STAGES-1:0] chain;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  raw;
    logic                  sync_nxt;

    assign raw = chain[NUM_STAGES-1];

    // Metastability chain; oldest sample sits in the MSB.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            chain <= {NUM_STAGES{INIT_BIT}};
        end else begin
            chain <= {chain[NUM_STAGES-2:0], ASYNC};
        end
    end

    // Stability filter: accept a new level only after it persists; bypass follows raw.
    always_comb begin
        sync_nxt = SYNC;
        cnt_nxt  = '0;
        if (FILT_BYPASS) begin
            sync_nxt = raw;
        end else if (raw != SYNC) begin
            if (cnt == CNT_LAST) begin
                sync_nxt = raw;
            end else begin
                cnt_nxt = cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Level change about to be committed, for the shared any-edge flop.
    assign edge_c = sync_nxt ^ SYNC;

    // Filtered level, counter and event pulses update on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            SYNC <= INIT_BIT;
            cnt  <= '0;
            RISE <= 1'b0;
            FALL <= 1'b0;
        end else begin
            SYNC <= sync_nxt;
            cnt  <= cnt_nxt;
            RISE <= sync_nxt & ~SYNC;
            FALL <= ~sync_nxt & SYNC;
        end
    end

endmodule

// File: rtl/multi_bit_sync_filter.sv
// Multi-channel level synchronizer with glitch filter and edge event pulses.
module multi_bit_sync_filter
    import multi_bit_sync_filter_pkg::*;
#(
    parameter int unsigned          NUM_STAGES    = DEF_NUM_STAGES,
    parameter int unsigned          BUS_WIDTH     = 4,
    parameter int unsigned          FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic [BUS_WIDTH-1:0] INIT_VAL      = {BUS_WIDTH{1'b0}}
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    input  logic                 FILT_BYPASS,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 ANY_EDGE
);

    logic [BUS_WIDTH-1:0] edge_c;

    // Reject configurations that cannot synchronize or filter.
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("multi_bit_sync_filter: NUM_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("multi_bit_sync_filter: BUS_WIDTH must be >= 1");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("multi_bit_sync_filter: FILTER_CYCLES must be >= 1");
    end

    // Independent per-channel synchronizer/filter.
    for (genvar i = 0; i < int'(BUS_WIDTH); i++) begin : g_chan
        sync_filter_chan #(
            .NUM_STAGES    (NUM_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .INIT_BIT      (INIT_VAL[i])
        ) u_chan (
            .CLK         (CLK),
            .RST         (RST),
            .ASYNC       (ASYNC[i]),
            .FILT_BYPASS (FILT_BYPASS),
            .SYNC        (SYNC[i]),
            .RISE        (RISE[i]),
            .FALL        (FALL[i]),
            .edge_c      (edge_c[i])
        );
    end

    // Any-channel event flag, coincident with the RISE/FALL pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ANY_EDGE <= 1'b0;
        end else begin
            ANY_EDGE <= |edge_c;
        end
    end

endmodule

// File: tb/tb_multi_bit_sync_filter.sv
// Scoreboard bench: stimulus queues expected events/levels, monitor checks them.
module tb_multi_bit_sync_filter;

    logic       clk;
    logic       rst;
    logic [3:0] async_a;
    logic       byp;
    logic [3:0] sync_a, rise_a, fall_a;
    logic       any_a;
    logic [3:0] async_b;
    logic [3:0] sync_b, rise_b, fall_b;
    logic       any_b;

    int cyc;
    int n_cmp;
    int n_bad;

    typedef struct {
        int       cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] sync;
    } evt_t;

    typedef struct {
        int       cyc;
        logic [3:0] sync;
    } lvl_t;

    evt_t evq[$];
    lvl_t lvq[$];

    multi_bit_sync_filter u_dut_a (
        .CLK         (clk),
        .RST         (rst),
        .ASYNC       (async_a),
        .FILT_BYPASS (byp),
        .SYNC        (sync_a),
        .RISE        (rise_a),
        .FALL        (fall_a),
        .ANY_EDGE    (any_a)
    );

    multi_bit_sync_filter #(
        .INIT_VAL (4'b1010)
    ) u_dut_b (
        .CLK         (clk),
        .RST         (rst),
        .ASYNC       (async_b),
        .FILT_BYPASS (byp),
        .SYNC        (sync_b),
        .RISE        (rise_b),
        .FALL        (fall_b),
        .ANY_EDGE    (any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_evt(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] s);
        evt_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.sync = s;
        evq.push_back(e);
    endtask

    task automatic exp_lvl(input int c, input logic [3:0] s);
        lvl_t l;
        l.cyc = c; l.sync = s;
        lvq.push_back(l);
    endtask

    // Monitor for DUT A: every event pulse must match the next queued expectation.
    always @(negedge clk) begin
        evt_t e;
        lvl_t l;
        if (any_a || (|rise_a) || (|fall_a)) begin
            if (evq.size() == 0) begin
                check("unexpected_event", {23'd0, any_a, rise_a, fall_a}, 32'd0);
            end else begin
                e = evq.pop_front();
                check("evt_cycle", cyc, e.cyc);
                check("evt_rise", {28'd0, rise_a}, {28'd0, e.rise});
                check("evt_fall", {28'd0, fall_a}, {28'd0, e.fall});
                check("evt_sync", {28'd0, sync_a}, {28'd0, e.sync});
                check("evt_any", {31'd0, any_a}, 32'd1);
            end
        end
        while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
            l = lvq.pop_front();
            check("lvl_cycle", cyc, l.cyc);
            check("lvl_sync", {28'd0, sync_a}, {28'd0, l.sync});
        end
    end

    // Monitor for DUT B: input equals reset value, so outputs never move.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("initval_quiet", {19'd0, sync_b, rise_b, fall_b, any_b}, {19'd0, 4'b1010, 4'b0, 4'b0, 1'b0});
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        byp     = 1'b0;
        async_a = 4'hF;
        async_b = 4'b1010;

        // Reset with all inputs high: SYNC held at INIT, then rises after full latency.
        exp_lvl(1, 4'h0);
        exp_lvl(2, 4'h0);
        exp_lvl(3, 4'h0);
        exp_lvl(8, 4'h0);
        exp_lvl(9, 4'hF);
        exp_evt(9, 4'hF, 4'h0, 4'hF);
        tick(3);
        rst = 1'b1;
        tick(10);

        // All channels back low.
        exp_evt(19, 4'h0, 4'hF, 4'h0);
        async_a = 4'h0;
        tick(10);

        // 3-cycle glitch on channel 0 is rejected.
        exp_lvl(32, 4'h0);
        async_a = 4'h1;
        tick(3);
        async_a = 4'h0;
        tick(10);

        // 4-cycle pulse on channel 0 passes: rise at p+6, fall 6 after the drop.
        exp_evt(42, 4'h1, 4'h0, 4'h1);
        exp_evt(46, 4'h0, 4'h1, 4'h0);
        async_a = 4'h1;
        tick(4);
        async_a = 4'h0;
        tick(16);

        // Bypass: 1-cycle pulse on channel 2 appears for exactly one cycle.
        exp_evt(59, 4'h4, 4'h0, 4'h4);
        exp_evt(60, 4'h0, 4'h4, 4'h0);
        byp     = 1'b1;
        async_a = 4'h4;
        tick(1);
        async_a = 4'h0;
        tick(9);
        byp = 1'b0;
        tick(4);

        // Channel 3 high, then simultaneous rise on 1 and fall on 3.
        exp_evt(76, 4'h8, 4'h0, 4'h8);
        async_a = 4'h8;
        tick(10);
        exp_evt(86, 4'h2, 4'h8, 4'h2);
        async_a = 4'h2;
        tick(10);

        // Reset while channel 0 rise is pending with count at 2.
        exp_lvl(95, 4'h0);
        exp_lvl(101, 4'h0);
        exp_lvl(102, 4'h3);
        exp_evt(102, 4'h3, 4'h0, 4'h3);
        async_a = 4'h3;
        tick(4);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(12);

        check("evq_drained", evq.size(), 32'd0);
        check("lvq_drained", lvq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
